// File: rtl/ascon_pack.sv
// ---------------------------------------------------------------------------
// ascon_pack
// Shared types and constants for the ASCON permutation datapath and the
// controller that sequences it.
//   type_state    : 320-bit permutation state {x0,x1,x2,x3,x4}, x0 in the MSBs
//   ctrl_state_t  : permutation_ctrl FSM states
//   rounds_sel_t  : round-count select (SEL_PA / SEL_PB / SEL_P6)
//   ROUND_LAST    : index of the final round of every permutation call
//   first_round() : first round-constant index for an N-round call
// ---------------------------------------------------------------------------
package ascon_pack;

    typedef logic [319:0] type_state;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    typedef logic [1:0] rounds_sel_t;

    localparam rounds_sel_t SEL_PA = 2'b00;
    localparam rounds_sel_t SEL_PB = 2'b01;
    localparam rounds_sel_t SEL_P6 = 2'b10;

    localparam logic [3:0] ROUND_LAST = 4'd11;

    // Every ASCON permutation call ends at round index 11, so an N-round
    // call starts at 12-N.
    function automatic logic [3:0] first_round(input int n_rounds);
        return 4'(12 - n_rounds);
    endfunction

endpackage

// File: rtl/round_counter.sv
// ---------------------------------------------------------------------------
// round_counter
// Round-constant index counter for the ASCON permutation.
//   clock_i    : clock, rising edge
//   rst_i      : synchronous active-low reset (clears the index to 0)
//   load_i     : load load_val_i (takes priority over en_i)
//   load_val_i : first round index of the call
//   en_i       : advance the index by one
//   round_o    : current round-constant index, never above ROUND_LAST
//   last_o     : terminal count, round_o is ROUND_LAST
// ---------------------------------------------------------------------------
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic [3:0] round_o,
    output logic       last_o
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of
    // statement order.
    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            round_o <= 4'd0;
        end else if (load_i) begin
            round_o <= load_val_i;
        end else if (en_i && (round_o != ROUND_LAST)) begin
            // Saturate at the last round so the index holds in CAPT/DONE.
            round_o <= round_o + 4'd1;
        end
    end

    assign last_o = (round_o == ROUND_LAST);

endmodule

// File: rtl/permutation_ctrl.sv
// ---------------------------------------------------------------------------
// permutation_ctrl
// Upstream sequencer for the ASCON permutation datapath. Accepts a 320-bit
// state and a round-count select, steps the free-running permutation through
// N rounds, captures the result and returns it on a valid/ack handshake.
//
// Parameters:
//   ROUNDS_A : rounds for p^a (initialisation/finalisation), default 12
//   ROUNDS_B : rounds for p^b (data processing), default 8
// Configuration macro:
//   ASCON_P6_EN : when defined, rounds_sel_i=2'b10 selects p^6 (first index
//                 6); when undefined 2'b10 behaves as 2'b11 (p^a).
// Ports:
//   clock_i      in   1    clock, rising edge
//   rst_i        in   1    synchronous active-low reset
//   start_i      in   1    request valid, accepted when start_i & ready_o
//   ready_o      out  1    high only in IDLE
//   rounds_sel_i in   2    round-count select, sampled on accept
//   S_i          in   320  input state, sampled on accept
//   init_state_o out  1    to permutation: high in the first RUN cycle only
//   round_o      out  4    to permutation: current round-constant index
//   S_perm_o     out  320  to permutation: captured input state
//   S_perm_i     in   320  from permutation: post-round state register
//   valid_o      out  1    result available, held until ack_i
//   ack_i        in   1    consumer ready, completes the transfer in DONE
//   S_o          out  320  captured result, stable while valid_o=1
// ---------------------------------------------------------------------------
module permutation_ctrl
    import ascon_pack::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic         clock_i,
    input  logic         rst_i,
    input  logic         start_i,
    output logic         ready_o,
    input  logic [1:0]   rounds_sel_i,
    input  logic [319:0] S_i,
    output logic         init_state_o,
    output logic [3:0]   round_o,
    output logic [319:0] S_perm_o,
    input  logic [319:0] S_perm_i,
    output logic         valid_o,
    input  logic         ack_i,
    output logic [319:0] S_o
);

    localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
    localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);
`ifdef ASCON_P6_EN
    localparam logic [3:0] FIRST_6 = first_round(6);
`endif

    ctrl_state_t state_q;
    logic        init_q;
    type_state   s_perm_q;
    type_state   s_out_q;

    logic        accept;
    logic [3:0]  first_idx;
    logic        round_last;

    assign accept = (state_q == IDLE) && start_i;

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        first_idx = FIRST_A;
        case (rounds_sel_i)
            SEL_PB:  first_idx = FIRST_B;
`ifdef ASCON_P6_EN
            SEL_P6:  first_idx = FIRST_6;
`endif
            default: first_idx = FIRST_A;
        endcase
    end

    // The terminal flag of the counter doubles as the remaining-count: the
    // index reaches 11 exactly after N-1 increments from 12-N.
    round_counter u_round_counter (
        .clock_i    (clock_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (first_idx),
        .en_i       (state_q == RUN),
        .round_o    (round_o),
        .last_o     (round_last)
    );

    // NOTE: the 320-bit state registers are reset as well, because a reset
    // mid-operation must clear S_o and S_perm_o rather than leave stale data.
    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            init_q   <= 1'b0;
            s_perm_q <= '0;
            s_out_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        s_perm_q <= S_i;
                        init_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    init_q <= 1'b0;
                    if (round_last) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    // The permutation register keeps running after the last
                    // round, so this is the only cycle holding the result.
                    s_out_q <= S_perm_i;
                    state_q <= DONE;
                end
                DONE: begin
                    if (ack_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign valid_o      = (state_q == DONE);
    assign init_state_o = init_q;
    assign S_perm_o     = s_perm_q;
    assign S_o          = s_out_q;

endmodule

// File: tb/tb_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_permutation_ctrl
// Self-checking bench for permutation_ctrl. A behavioural ASCON permutation
// register is attached to the datapath ports; expected results come from a
// golden round function applied directly to the requested input state.
// Honours ASCON_P6_EN the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_permutation_ctrl;

    logic         clock_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic         ready_o;
    logic [1:0]   rounds_sel_i = 2'b00;
    logic [319:0] S_i = '0;
    logic         init_state_o;
    logic [3:0]   round_o;
    logic [319:0] S_perm_o;
    logic [319:0] S_perm_i;
    logic         valid_o;
    logic         ack_i = 1'b0;
    logic [319:0] S_o;

    always #5 clock_i = ~clock_i;

    permutation_ctrl dut (
        .clock_i      (clock_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .rounds_sel_i (rounds_sel_i),
        .S_i          (S_i),
        .init_state_o (init_state_o),
        .round_o      (round_o),
        .S_perm_o     (S_perm_o),
        .S_perm_i     (S_perm_i),
        .valid_o      (valid_o),
        .ack_i        (ack_i),
        .S_o          (S_o)
    );

    // ----------------------------------------------------------- golden model
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [3:0]  hi;
        {x0, x1, x2, x3, x4} = s;
        hi = 4'hf - r;
        x2 = x2 ^ {56'd0, hi, r};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] ascon_perm(input logic [319:0] s, input int n);
        logic [319:0] t;
        t = s;
        for (int r = 12 - n; r < 12; r++) t = ascon_round(t, 4'(r));
        return t;
    endfunction

    function automatic int sel_to_n(input logic [1:0] sel);
        int n;
        n = 12;
        if (sel == 2'b01) n = 8;
`ifdef ASCON_P6_EN
        if (sel == 2'b10) n = 6;
`endif
        return n;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // Free-running permutation state register.
    logic [319:0] perm_q = '0;
    always @(posedge clock_i) perm_q <= ascon_round(init_state_o ? S_perm_o : perm_q, round_o);
    assign S_perm_i = perm_q;

    // ----------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // ----------------------------------------------------------- scoreboard monitor
    typedef struct {
        logic [319:0] s;
        int           n;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   active   = 1'b0;
    int   acc_edge = 0;
    int   cur_n    = 0;
    int   acc_cnt  = 0;
    int   done_cnt = 0;
    int   k;

    always @(posedge clock_i) edge_cnt++;

    // Samples on the falling edge; k counts edges since (and including) the
    // accept edge, so k=1..N is RUN, k=N+1 is CAPT and k>=N+2 is DONE.
    always @(negedge clock_i) begin
        if (mon_en) begin
            if (!rst_i) begin
                active = 1'b0;
                sb.delete();
            end else if (active) begin
                k = edge_cnt - acc_edge + 1;
                check("busy_ready", ready_o, 1'b0);
                if (k <= cur_n) begin
                    check("run_round", round_o, 12 - cur_n + k - 1);
                    check("run_init", init_state_o, k == 1);
                    check("run_valid", valid_o, 1'b0);
                end else if (k == cur_n + 1) begin
                    check("capt_round", round_o, 11);
                    check("capt_init", init_state_o, 1'b0);
                    check("capt_valid", valid_o, 1'b0);
                end else begin
                    check("done_valid", valid_o, 1'b1);
                    check("done_round", round_o, 11);
                    if (sb.size() > 0) check("done_S_o", S_o, sb[0].s);
                    if (valid_o && ack_i) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        active = 1'b0;
                        done_cnt++;
                    end
                end
            end else begin
                check("idle_ready", ready_o, 1'b1);
                check("idle_valid", valid_o, 1'b0);
                check("idle_init", init_state_o, 1'b0);
                if (start_i) begin
                    active   = 1'b1;
                    acc_edge = edge_cnt + 1;
                    cur_n    = sel_to_n(rounds_sel_i);
                    sb.push_back('{s: ascon_perm(S_i, cur_n), n: cur_n});
                    acc_cnt++;
                end
            end
        end
    end

    // ----------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, ready_o, 1'b1);
        check({tag, "_valid"}, valid_o, 1'b0);
        check({tag, "_init"}, init_state_o, 1'b0);
        check({tag, "_round"}, round_o, 4'd0);
        check({tag, "_S_perm_o"}, S_perm_o, '0);
        check({tag, "_S_o"}, S_o, '0);
    endtask

    // Waits for the edge at which the pending start_i is taken.
    task automatic wait_accept(input string tag);
        logic was_ready;
        bit   ok;
        ok = 1'b0;
        for (int b = 0; b < 50 && !ok; b++) begin
            was_ready = ready_o;
            tick();
            if (was_ready) ok = 1'b1;
        end
        if (!ok) check({tag, "_accept_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int b = 0; b < 40 && !ok; b++) begin
            if (valid_o) ok = 1'b1;
            else tick();
        end
        if (!ok) check({tag, "_valid_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int b = 0; b < 80 && !ok; b++) begin
            if (!active && sb.size() == 0) ok = 1'b1;
            else tick();
        end
        if (!ok) check({tag, "_idle_timeout"}, 1'b0, 1'b1);
    endtask

    // One full transaction; select and state are scrambled right after the
    // accept edge to show they are no longer sampled.
    task automatic transact(input string tag, input logic [1:0] sel,
                            input logic [319:0] s, input int ack_delay);
        start_i      = 1'b1;
        rounds_sel_i = sel;
        S_i          = s;
        wait_accept(tag);
        start_i      = 1'b0;
        rounds_sel_i = ~sel;
        S_i          = ~s;
        wait_valid(tag);
        repeat (ack_delay) tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        wait_idle(tag);
        tick();
    endtask

    // ----------------------------------------------------------- stimulus
    logic [319:0] aead_init;
    int           prev_acc;
    int           prev_done;

    initial begin
        aead_init = {64'h00001000808c0001,
                     128'h000102030405060708090a0b0c0d0e0f,
                     128'h101112131415161718191a1b1c1d1e1f};

        // Reset state.
        rst_i = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        rst_i  = 1'b1;
        mon_en = 1'b1;
        tick();

        // p^12 on the zero state, then p^8 on the AEAD initial state.
        transact("pa_zero", 2'b00, '0, 3);
        transact("pb_aead", 2'b01, aead_init, 0);
        transact("pa_sel11", 2'b11, rand_state(), 1);
        // 2'b10: p^6 with the macro, p^12 without.
        transact("p6_sel10", 2'b10, rand_state(), 0);

        // start_i held high while the result waits 20 cycles in DONE.
        prev_acc     = acc_cnt;
        start_i      = 1'b1;
        rounds_sel_i = 2'b00;
        S_i          = rand_state();
        wait_accept("hold");
        S_i = rand_state();
        wait_valid("hold");
        repeat (20) tick();
        check("hold_single_accept", acc_cnt, prev_acc + 1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        wait_accept("hold_next");
        start_i = 1'b0;
        check("hold_next_accept", acc_cnt, prev_acc + 2);
        wait_valid("hold_next");
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        wait_idle("hold_next");
        tick();

        // Reset in the middle of a p^12 run at round 6.
        start_i      = 1'b1;
        rounds_sel_i = 2'b00;
        S_i          = rand_state();
        wait_accept("abort");
        start_i = 1'b0;
        for (int b = 0; b < 20 && round_o != 4'd6; b++) tick();
        check("abort_at_round6", round_o, 4'd6);
        rst_i = 1'b0;
        tick();
        check_reset_values("abort");
        rst_i = 1'b1;
        tick();
        transact("after_abort", 2'b00, rand_state(), 2);

        // Back-to-back p^8 then p^12 with ack_i tied high.
        prev_done    = done_cnt;
        ack_i        = 1'b1;
        start_i      = 1'b1;
        rounds_sel_i = 2'b01;
        S_i          = rand_state();
        wait_accept("b2b_first");
        rounds_sel_i = 2'b00;
        S_i          = rand_state();
        wait_accept("b2b_second");
        start_i = 1'b0;
        wait_idle("b2b");
        ack_i = 1'b0;
        check("b2b_done_count", done_cnt, prev_done + 2);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
